pau_result_buffer: RTL and testbench

//  Downstream stage of the posit arithmetic unit (PAU) coprocessor on the CVXIF path.
//  - Snoops the issue handshake and captures each accepted instruction's rd field in a tag FIFO.
//  - Pairs each PAU result with its tag and queues the pair in a result FIFO.
//  - Presents queued results to the core writeback port with a valid/ready handshake.
//  - Decouples PAU completion from core writeback back-pressure.

---
 rtl/pau_result_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_pau_result_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pau_result_buffer.sv
// pau_result_buffer
//   Writeback-side buffer for the posit arithmetic unit. Snoops accepted issue handshakes and
//   queues their rd fields in a tag FIFO. Pairs each PAU result with the oldest tag and queues
//   {rd, data} in a first-word-fall-through result FIFO. Presents the head entry to the core
//   with a valid/ready handshake.
//
// Parameters
//   TAG_DEPTH  rd tag FIFO entries (power of two, >= 2)
//   RES_DEPTH  result FIFO entries (power of two, >= 2)
//   XLEN       result data width
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   issue_valid/ready/resp_accept, issue_req_instr
//                               snooped issue handshake; rd = instr[11:7]
//   pau_result_valid/ready/data PAU result handshake
//   core_result_valid/ready     core writeback handshake
//   core_result_data/rd/we      head entry; we = 0 when rd == 0
//   tag_overflow                sticky: accept seen while the tag FIFO was full
//
// Optional feature (macro PAU_RESBUF_STATS_EN)
//   res_total  count of core pops, wraps at 2^32
//   wb_stall   cycles with core_result_valid & !core_result_ready, wraps at 2^32

module pau_result_buffer #(
  parameter int unsigned TAG_DEPTH = 2,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_ready,
  input  logic            issue_resp_accept,
  input  logic [31:0]     issue_req_instr,
  input  logic            pau_result_valid,
  output logic            pau_result_ready,
  input  logic [XLEN-1:0] pau_result_data,
  output logic            core_result_valid,
  input  logic            core_result_ready,
  output logic [XLEN-1:0] core_result_data,
  output logic [4:0]      core_result_rd,
  output logic            core_result_we,
  output logic            tag_overflow
`ifdef PAU_RESBUF_STATS_EN
  ,
  output logic [31:0]     res_total,
  output logic [31:0]     wb_stall
`endif
);

  localparam int unsigned TPW = $clog2(TAG_DEPTH);
  localparam int unsigned TCW = TPW + 1;
  localparam int unsigned RPW = $clog2(RES_DEPTH);
  localparam int unsigned RCW = RPW + 1;

  localparam logic [TCW-1:0] TagFull = TCW'(TAG_DEPTH);
  localparam logic [RCW-1:0] ResFull = RCW'(RES_DEPTH);

  // Tag FIFO state
  logic [4:0]     tag_mem_q [TAG_DEPTH];
  logic [4:0]     tag_mem_d [TAG_DEPTH];
  logic [TPW-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
  logic [TPW-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
  logic [TCW-1:0] tag_count_q, tag_count_d;
  logic           overflow_q, overflow_d;

  // Result FIFO state
  logic [XLEN-1:0] res_data_q [RES_DEPTH];
  logic [XLEN-1:0] res_data_d [RES_DEPTH];
  logic [4:0]      res_rd_q   [RES_DEPTH];
  logic [4:0]      res_rd_d   [RES_DEPTH];
  logic [RPW-1:0]  res_wr_ptr_q, res_wr_ptr_d;
  logic [RPW-1:0]  res_rd_ptr_q, res_rd_ptr_d;
  logic [RCW-1:0]  res_count_q, res_count_d;

  logic accept;
  logic tag_full, tag_empty, res_full;
  logic tag_push, tag_pop, res_push, res_pop;

  assign accept    = issue_valid & issue_ready & issue_resp_accept;
  assign tag_full  = (tag_count_q == TagFull);
  assign tag_empty = (tag_count_q == '0);
  assign res_full  = (res_count_q == ResFull);

  // Ready comes from registered counts only: a tag pushed this cycle is not usable until the
  // next, and core pops free room only from the next cycle.
  assign pau_result_ready  = ~res_full & ~tag_empty;
  assign core_result_valid = (res_count_q != '0);

  assign tag_push = accept & ~tag_full;
  assign res_push = pau_result_valid & pau_result_ready;
  assign tag_pop  = res_push;
  assign res_pop  = core_result_valid & core_result_ready;

  always_comb begin
    tag_mem_d    = tag_mem_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_count_d  = tag_count_q;
    overflow_d   = overflow_q | (accept & tag_full);
    if (tag_push) begin
      tag_mem_d[tag_wr_ptr_q] = issue_req_instr[11:7];
      tag_wr_ptr_d            = tag_wr_ptr_q + TPW'(1);
    end
    if (tag_pop) begin
      tag_rd_ptr_d = tag_rd_ptr_q + TPW'(1);
    end
    unique case ({tag_push, tag_pop})
      2'b10:   tag_count_d = tag_count_q + TCW'(1);
      2'b01:   tag_count_d = tag_count_q - TCW'(1);
      default: tag_count_d = tag_count_q;
    endcase
  end

  always_comb begin
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    res_wr_ptr_d = res_wr_ptr_q;
    res_rd_ptr_d = res_rd_ptr_q;
    res_count_d  = res_count_q;
    if (res_push) begin
      res_data_d[res_wr_ptr_q] = pau_result_data;
      res_rd_d[res_wr_ptr_q]   = tag_mem_q[tag_rd_ptr_q];
      res_wr_ptr_d             = res_wr_ptr_q + RPW'(1);
    end
    if (res_pop) begin
      res_rd_ptr_d = res_rd_ptr_q + RPW'(1);
    end
    unique case ({res_push, res_pop})
      2'b10:   res_count_d = res_count_q + RCW'(1);
      2'b01:   res_count_d = res_count_q - RCW'(1);
      default: res_count_d = res_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mem_q    <= '{default: '0};
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_count_q  <= '0;
      overflow_q   <= 1'b0;
      res_data_q   <= '{default: '0};
      res_rd_q     <= '{default: '0};
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_count_q  <= '0;
    end else begin
      tag_mem_q    <= tag_mem_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_count_q  <= tag_count_d;
      overflow_q   <= overflow_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      res_wr_ptr_q <= res_wr_ptr_d;
      res_rd_ptr_q <= res_rd_ptr_d;
      res_count_q  <= res_count_d;
    end
  end

  // Head entry is read straight from storage flops; zeroed while empty so the port is quiet.
  always_comb begin
    core_result_data = '0;
    core_result_rd   = '0;
    if (core_result_valid) begin
      core_result_data = res_data_q[res_rd_ptr_q];
      core_result_rd   = res_rd_q[res_rd_ptr_q];
    end
  end

  assign core_result_we = core_result_valid & (core_result_rd != 5'd0);
  assign tag_overflow   = overflow_q;

`ifdef PAU_RESBUF_STATS_EN
  logic [31:0] res_total_q, res_total_d;
  logic [31:0] wb_stall_q, wb_stall_d;

  always_comb begin
    res_total_d = res_total_q;
    wb_stall_d  = wb_stall_q;
    if (res_pop) begin
      res_total_d = res_total_q + 32'd1;
    end
    if (core_result_valid & ~core_result_ready) begin
      wb_stall_d = wb_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_total_q <= '0;
      wb_stall_q  <= '0;
    end else begin
      res_total_q <= res_total_d;
      wb_stall_q  <= wb_stall_d;
    end
  end

  assign res_total = res_total_q;
  assign wb_stall  = wb_stall_q;
`endif

endmodule

// File: tb/tb_pau_result_buffer.sv
module tb_pau_result_buffer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_resp_accept;
  logic [31:0] issue_req_instr;
  logic        pau_result_valid;
  logic        pau_result_ready;
  logic [31:0] pau_result_data;
  logic        core_result_valid;
  logic        core_result_ready;
  logic [31:0] core_result_data;
  logic [4:0]  core_result_rd;
  logic        core_result_we;
  logic        tag_overflow;
`ifdef PAU_RESBUF_STATS_EN
  logic [31:0] res_total;
  logic [31:0] wb_stall;
`endif

  pau_result_buffer #(
    .TAG_DEPTH(2),
    .RES_DEPTH(4),
    .XLEN     (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_resp_accept(issue_resp_accept),
    .issue_req_instr  (issue_req_instr),
    .pau_result_valid (pau_result_valid),
    .pau_result_ready (pau_result_ready),
    .pau_result_data  (pau_result_data),
    .core_result_valid(core_result_valid),
    .core_result_ready(core_result_ready),
    .core_result_data (core_result_data),
    .core_result_rd   (core_result_rd),
    .core_result_we   (core_result_we),
    .tag_overflow     (tag_overflow)
`ifdef PAU_RESBUF_STATS_EN
    ,
    .res_total        (res_total),
    .wb_stall         (wb_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;

  // Reference model: tag queue, result scoreboard, sticky overflow, stats counters.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic [4:0]  tq[$];
  ent_t        rq[$];
  logic        ovf_m;
  int unsigned pops_m;
  int unsigned stalls_m;

  typedef struct {
    logic [2:0]  iss;   // {valid, ready, resp_accept}
    logic [4:0]  rd;
    logic        pv;
    logic [31:0] data;
    logic        cr;
    logic        exp_prdy;
    logic        exp_cvld;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic vec_t mk(input logic [2:0] iss, input logic [4:0] rd, input logic pv,
                              input logic [31:0] data, input logic cr, input logic prdy,
                              input logic cvld);
    vec_t v;
    v.iss      = iss;
    v.rd       = rd;
    v.pv       = pv;
    v.data     = data;
    v.cr       = cr;
    v.exp_prdy = prdy;
    v.exp_cvld = cvld;
    return v;
  endfunction

  // One clock: drive inputs, compare against the model, advance the model, tick.
  task automatic cycle(input logic [2:0] iss, input logic [4:0] rd, input logic pv,
                       input logic [31:0] data, input logic cr);
    logic [31:0] instr;
    logic        mrdy;
    logic        mvld;
    logic        tfull;
    logic        do_pop;
    ent_t        e;
    instr       = $urandom();
    instr[11:7] = rd;
    {issue_valid, issue_ready, issue_resp_accept} = iss;
    issue_req_instr   = instr;
    pau_result_valid  = pv;
    pau_result_data   = data;
    core_result_ready = cr;

    mrdy = (rq.size() < 4) && (tq.size() > 0);
    mvld = (rq.size() > 0);
    chk("pau_result_ready", 32'(pau_result_ready), 32'(mrdy));
    chk("core_result_valid", 32'(core_result_valid), 32'(mvld));
    chk("tag_overflow", 32'(tag_overflow), 32'(ovf_m));
    if (mvld) begin
      chk("core_result_data", core_result_data, rq[0].data);
      chk("core_result_rd", 32'(core_result_rd), 32'(rq[0].rd));
      chk("core_result_we", 32'(core_result_we), 32'(rq[0].rd != 5'd0));
    end

    tfull  = (tq.size() == 2);
    do_pop = mvld && cr;
    if (mvld && !cr) stalls_m++;
    if (do_pop) begin
      void'(rq.pop_front());
      pops_m++;
    end
    if (pv && mrdy) begin
      e.rd   = tq.pop_front();
      e.data = data;
      rq.push_back(e);
    end
    if (&iss) begin
      if (tfull) ovf_m = 1'b1;
      else tq.push_back(rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    issue_valid       = 1'b0;
    issue_ready       = 1'b0;
    issue_resp_accept = 1'b0;
    issue_req_instr   = '0;
    pau_result_valid  = 1'b0;
    pau_result_data   = '0;
    core_result_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_core_valid", 32'(core_result_valid), 32'd0);
    chk("rst_core_data", core_result_data, 32'd0);
    chk("rst_core_rd", 32'(core_result_rd), 32'd0);
    chk("rst_core_we", 32'(core_result_we), 32'd0);
    chk("rst_overflow", 32'(tag_overflow), 32'd0);
    chk("rst_pau_ready", 32'(pau_result_ready), 32'd0);
`ifdef PAU_RESBUF_STATS_EN
    chk("rst_res_total", res_total, 32'd0);
    chk("rst_wb_stall", wb_stall, 32'd0);
`endif
    rst = 1'b0;
    tq.delete();
    rq.delete();
    ovf_m    = 1'b0;
    pops_m   = 0;
    stalls_m = 0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Single results (rd=5, rd=0), no-tag stall, no bypass, same-cycle tag push+pop.
    vecs[0]  = mk(3'b111, 5'd5, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(3'b000, 5'd0, 1'b1, 32'h40000000, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    vecs[3]  = mk(3'b111, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(3'b000, 5'd0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    vecs[6]  = mk(3'b000, 5'd0, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(3'b111, 5'd9, 1'b1, 32'hAAAA0001, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(3'b000, 5'd0, 1'b1, 32'hAAAA0001, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1);
    vecs[10] = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    vecs[11] = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    vecs[12] = mk(3'b111, 5'd3, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);
    vecs[13] = mk(3'b111, 5'd4, 1'b1, 32'hD0000001, 1'b1, 1'b1, 1'b0);
    vecs[14] = mk(3'b000, 5'd0, 1'b1, 32'hD0000002, 1'b0, 1'b1, 1'b1);
    vecs[15] = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    vecs[16] = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    vecs[17] = mk(3'b000, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0);

    do_reset();
    do_reset();

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("vec%0d_pau_ready", i), 32'(pau_result_ready), 32'(vecs[i].exp_prdy));
      chk($sformatf("vec%0d_core_valid", i), 32'(core_result_valid), 32'(vecs[i].exp_cvld));
      cycle(vecs[i].iss, vecs[i].rd, vecs[i].pv, vecs[i].data, vecs[i].cr);
    end

    // Incomplete handshake (no resp_accept) must not queue a tag.
    cycle(3'b110, 5'd20, 1'b1, 32'hBEEF0000, 1'b1);
    cycle(3'b000, 5'd0, 1'b1, 32'hBEEF0000, 1'b1);
    chk("partial_hs_no_tag", 32'(pau_result_ready), 32'd0);
    cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b1);

    // Fill result FIFO with core stalled, then full + pop in the same cycle, then drain.
    for (int i = 1; i <= 4; i++) begin
      cycle(3'b111, 5'(i), (i > 1), 32'hC000_0000 + 32'(i - 1), 1'b0);
    end
    cycle(3'b000, 5'd0, 1'b1, 32'hC000_0004, 1'b0);
    cycle(3'b111, 5'd5, 1'b0, 32'h0, 1'b0);
    chk("full_pau_ready", 32'(pau_result_ready), 32'd0);
    chk("full_head_rd", 32'(core_result_rd), 32'd1);
    cycle(3'b000, 5'd0, 1'b1, 32'hC000_0005, 1'b1);
    cycle(3'b000, 5'd0, 1'b1, 32'hC000_0005, 1'b1);
    for (int i = 0; i < 5; i++) cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b1);

    // Tag overflow: three accepts with no results; sticky; first two tags survive.
    do_reset();
    cycle(3'b111, 5'd10, 1'b0, 32'h0, 1'b0);
    cycle(3'b111, 5'd11, 1'b0, 32'h0, 1'b0);
    cycle(3'b111, 5'd12, 1'b0, 32'h0, 1'b0);
    chk("overflow_set", 32'(tag_overflow), 32'd1);
    cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b0);
    cycle(3'b000, 5'd0, 1'b1, 32'hE000_000A, 1'b0);
    cycle(3'b000, 5'd0, 1'b1, 32'hE000_000B, 1'b0);
    cycle(3'b000, 5'd0, 1'b1, 32'hE000_000C, 1'b0);
    chk("overflow_sticky", 32'(tag_overflow), 32'd1);
    do_reset();  // mid-operation reset discards the two queued results
    cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b1);

    // Writeback stall: data/rd held for 3 cycles, then popped.
    do_reset();
    cycle(3'b111, 5'd7, 1'b0, 32'h0, 1'b1);
    cycle(3'b000, 5'd0, 1'b1, 32'h7777_0007, 1'b0);
    for (int i = 0; i < 3; i++) cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b0);
    cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b1);
    cycle(3'b000, 5'd0, 1'b0, 32'h0, 1'b1);
`ifdef PAU_RESBUF_STATS_EN
    chk("wb_stall", wb_stall, 32'd3);
    chk("res_total", res_total, 32'd1);
    chk("wb_stall_model", wb_stall, stalls_m);
    chk("res_total_model", res_total, pops_m);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
